delay_monitor: RTL



---
 rtl/delay_pkg.sv | 27 ++
 rtl/delay_monitor_gap_counter.sv | 27 ++
 rtl/delay_monitor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/delay_pkg.sv
// delay_pkg: shared state type, default threshold and window helpers
// for the delay stage and the period monitor that consumes its pulse.
package delay_pkg;

  localparam int N_DEFAULT    = 17500;
  localparam int TOL_DEFAULT  = 4;
  localparam int LOCK_DEFAULT = 3;

  localparam int WIN_LO_DEFAULT = N_DEFAULT + 1 - TOL_DEFAULT;
  localparam int WIN_HI_DEFAULT = N_DEFAULT + 1 + TOL_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK,
    LOST
  } state_t;

  function automatic int win_lo(input int n, input int tol);
    return n + 1 - tol;
  endfunction

  function automatic int win_hi(input int n, input int tol);
    return n + 1 + tol;
  endfunction

endpackage

// File: rtl/delay_monitor_gap_counter.sv
// gap_counter: cycles since the last accepted tick.
// Loads 1 on a tick, otherwise counts up and saturates at all-ones.
module gap_counter
  import delay_pkg::*;
#(
  parameter int CBITS = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  output logic [CBITS-1:0] count
);

  localparam logic [CBITS-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= CBITS'(1);
    end else if (count != MAX) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/delay_monitor.sv
// delay_monitor: checks tick spacing against N+1 +/- TOL, tracks lock/loss.
// Define STICKY_ERR_EN to build the sticky err_flag; otherwise it is tied 0.
module delay_monitor
  import delay_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int TOL      = TOL_DEFAULT,
  parameter int LOCK_CNT = LOCK_DEFAULT,
  parameter int CBITS    = 15,
  parameter int TCBITS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tick,
  output logic              locked,
  output logic              early,
  output logic              late,
  output logic              timeout,
  output logic [CBITS-1:0]  period,
  output logic [TCBITS-1:0] tick_cnt,
  output logic              err_flag
);

  localparam logic [CBITS-1:0] LO = CBITS'(win_lo(N, TOL));
  localparam logic [CBITS-1:0] HI = CBITS'(win_hi(N, TOL));
  localparam int GBITS = $clog2(LOCK_CNT + 1);
  localparam logic [GBITS-1:0] LOCK_MAX = GBITS'(LOCK_CNT);

  if (win_hi(N, TOL) >= (1 << CBITS)) begin : g_cbits_chk
    $error("delay_monitor: CBITS too small for N+1+TOL");
  end

  state_t           state;
  logic [GBITS-1:0] good_run;
  logic [CBITS-1:0] count;
  logic             accept;
  logic             clear;
  logic             is_early;
  logic             is_late;

  assign accept   = en && tick && (state != IDLE);
  assign clear    = !en || (state == IDLE);
  assign is_early = accept && (state == TRACK) && (count < LO);
  assign is_late  = en && !tick && (state == TRACK) && (count >= HI);

  gap_counter #(
    .CBITS (CBITS)
  ) u_gap (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .load  (accept),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      good_run <= '0;
      locked   <= 1'b0;
      early    <= 1'b0;
      late     <= 1'b0;
      timeout  <= 1'b0;
      period   <= '0;
      tick_cnt <= '0;
    end else begin
      early <= 1'b0;
      late  <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        good_run <= '0;
        locked   <= 1'b0;
        timeout  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (tick) begin
              state    <= TRACK;
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          TRACK: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 1'b1;
              period   <= count;
              if (is_early) begin
                early    <= 1'b1;
                good_run <= '0;
                locked   <= 1'b0;
              end else if (good_run != LOCK_MAX) begin
                good_run <= good_run + 1'b1;
                locked   <= (good_run == LOCK_MAX - 1'b1);
              end
            end else if (is_late) begin
              late     <= 1'b1;
              locked   <= 1'b0;
              good_run <= '0;
              timeout  <= 1'b1;
              state    <= LOST;
            end
          end
          LOST: begin
            if (tick) begin
              state    <= TRACK;
              timeout  <= 1'b0;
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      err_flag <= 1'b0;
    end else if (is_early || is_late) begin
      err_flag <= 1'b1;
    end
  end
`else
  assign err_flag = 1'b0;
`endif

endmodule
